// File: rtl/master_port.sv
// Purpose: serialises one parallel request into address, slave ack, write/read byte, completion on the B_* bus.
// Latency: accept to M_DONE = 16 address + ack wait + 8 data (+ ack wait for writes) + 1 cycles.
// Backpressure: M_READY only in IDLE; B_SBSY holds off acceptance; a missing ack aborts with an M_ERR pulse.
module master_port #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  M_EXECUTE,
    input  logic                  M_RW,
    input  logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic [DATA_WIDTH-1:0] M_DIN,
    output logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DOUT,
    output logic                  M_DONE,
    output logic                  M_ERR,
    output logic                  AD_SEL,
    output logic                  B_RW,
    output logic                  B_BUS_OUT,
    input  logic                  B_ACK,
    input  logic                  B_SBSY,
    input  logic                  B_BUS_IN
);

    localparam int AW = $clog2(ADDR_WIDTH);
    localparam int DW = $clog2(DATA_WIDTH);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_WIDTH - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_WIDTH - 1);
    localparam logic [4:0] ACK_LAST  = 5'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ADDRESS, ACK_A, WRITE, READ, ACK_W, DONE
    } state_t;

    state_t                state, state_nxt;
    logic [4:0]            cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q, rdata_q, rdata_upd;
    logic                  rw_q, rw_nxt;
    logic                  ack_seen;
    logic                  accept, in_ack, ack_fall, err_nxt, bus_out_nxt;

    assign accept   = (state == IDLE) && M_EXECUTE && !B_SBSY;
    assign in_ack   = (state == ACK_A) || (state == ACK_W);
    assign ack_fall = in_ack && ack_seen && !B_ACK;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 5'd1;
        err_nxt   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = ADDRESS;
            ADDRESS: if (cnt == ADDR_LAST) state_nxt = ACK_A;
            ACK_A, ACK_W: begin
                // A falling edge on the final counted cycle still wins over the timeout.
                if (ack_fall) begin
                    if (state == ACK_W) state_nxt = DONE;
                    else                state_nxt = rw_q ? WRITE : READ;
                end else if (cnt == ACK_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            WRITE:   if (cnt == DATA_LAST) state_nxt = ACK_W;
            READ:    if (cnt == DATA_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state || state == IDLE) cnt_nxt = 5'd0;
    end

    always_comb begin
        bus_out_nxt = 1'b0;
        if (state_nxt == ADDRESS)
            bus_out_nxt = accept ? M_ADDR[0] : addr_q[cnt_nxt[AW-1:0]];
        else if (state_nxt == WRITE)
            bus_out_nxt = data_q[cnt_nxt[DW-1:0]];
    end

    always_comb begin
        rdata_upd = rdata_q;
        rdata_upd[cnt[DW-1:0]] = B_BUS_IN;
        rw_nxt = accept ? M_RW : rw_q;
        if (state_nxt == IDLE || state_nxt == DONE) rw_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            rw_q      <= 1'b0;
            ack_seen  <= 1'b0;
            M_READY   <= 1'b1;
            M_DOUT    <= '0;
            M_DONE    <= 1'b0;
            M_ERR     <= 1'b0;
            AD_SEL    <= 1'b0;
            B_RW      <= 1'b0;
            B_BUS_OUT <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            if (accept) begin
                addr_q <= M_ADDR;
                data_q <= M_DIN;
                rw_q   <= M_RW;
            end
            // Remembers that the slave raised ACK since entering the current ack wait.
            ack_seen <= in_ack && (state_nxt == state) && (ack_seen || B_ACK);
            if (state == READ) begin
                rdata_q <= rdata_upd;
                if (state_nxt == DONE) M_DOUT <= rdata_upd;
            end
            M_READY   <= (state_nxt == IDLE);
            M_DONE    <= (state_nxt == DONE);
            M_ERR     <= err_nxt;
            AD_SEL    <= (state_nxt == ADDRESS);
            B_RW      <= rw_nxt;
            B_BUS_OUT <= bus_out_nxt;
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Directed and randomised transactions against a cycle-level slave/bus model of master_port.
module tb_master_port;

    localparam int ACK_TO = 8;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        M_EXECUTE, M_RW;
    logic [15:0] M_ADDR;
    logic [7:0]  M_DIN;
    logic        M_READY;
    logic [7:0]  M_DOUT;
    logic        M_DONE, M_ERR, AD_SEL, B_RW, B_BUS_OUT;
    logic        B_ACK, B_SBSY, B_BUS_IN;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_dout = 8'h00;
    bit   prev_done = 1'b0;

    master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ACK_TIMEOUT(ACK_TO)) dut (
        .CLK(CLK), .RSTN(RSTN), .M_EXECUTE(M_EXECUTE), .M_RW(M_RW), .M_ADDR(M_ADDR),
        .M_DIN(M_DIN), .M_READY(M_READY), .M_DOUT(M_DOUT), .M_DONE(M_DONE), .M_ERR(M_ERR),
        .AD_SEL(AD_SEL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT), .B_ACK(B_ACK),
        .B_SBSY(B_SBSY), .B_BUS_IN(B_BUS_IN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave handshake: ACK high from cycle d for h cycles; success iff it falls before the timeout.
    task automatic ack_model(input int d, input int h, input logic rw, output bit ok);
        ok = (h > 0) && (d + h < ACK_TO);
        for (int c = 0; c < ACK_TO; c++) begin
            B_ACK = (c >= d) && (c < d + h);
            chk("ack_adsel", 16'(AD_SEL), 16'h0);
            chk("ack_busout", 16'(B_BUS_OUT), 16'h0);
            chk("ack_rw", 16'(B_RW), 16'(rw));
            chk("ack_done", 16'(M_DONE), 16'h0);
            chk("ack_err", 16'(M_ERR), 16'h0);
            @(negedge CLK);
            if (ok && c == d + h) break;
        end
        B_ACK = 1'b0;
    endtask

    task automatic timeout_checks();
        chk("to_err", 16'(M_ERR), 16'h1);
        chk("to_done", 16'(M_DONE), 16'h0);
        chk("to_ready", 16'(M_READY), 16'h1);
        chk("to_rw", 16'(B_RW), 16'h0);
        chk("to_dout", 16'(M_DOUT), 16'(exp_dout));
        prev_done = 1'b0;
    endtask

    task automatic do_txn(input logic rw, input logic [15:0] addr, input logic [7:0] data,
                          input logic [7:0] rdat, input int d1, input int h1,
                          input int d2, input int h2, input int abort_bit);
        int waited;
        int exp_wait;
        bit ok;
        exp_wait  = prev_done ? 2 : 1;
        M_EXECUTE = 1'b1;
        M_RW      = rw;
        M_ADDR    = addr;
        M_DIN     = data;
        @(negedge CLK);
        waited = 1;
        while (AD_SEL !== 1'b1 && waited < 40) begin
            chk("idle_ready", 16'(M_READY), 16'h1);
            chk("idle_done", 16'(M_DONE), 16'h0);
            @(negedge CLK);
            waited++;
        end
        chk("accept_wait", 16'(waited), 16'(exp_wait));
        if (waited >= 40) return;
        M_EXECUTE = 1'b0;
        M_RW      = 1'($urandom);
        M_ADDR    = 16'($urandom);
        M_DIN     = 8'($urandom);
        chk("busy_ready", 16'(M_READY), 16'h0);
        for (int i = 0; i < 16; i++) begin
            chk("addr_adsel", 16'(AD_SEL), 16'h1);
            chk("addr_bit", 16'(B_BUS_OUT), 16'((addr >> i) & 16'h1));
            chk("addr_rw", 16'(B_RW), 16'(rw));
            if (i == abort_bit) begin
                RSTN = 1'b0;
                #1;
                exp_dout  = 8'h00;
                prev_done = 1'b0;
                chk("rst_adsel", 16'(AD_SEL), 16'h0);
                chk("rst_busout", 16'(B_BUS_OUT), 16'h0);
                chk("rst_rw", 16'(B_RW), 16'h0);
                chk("rst_ready", 16'(M_READY), 16'h1);
                chk("rst_dout", 16'(M_DOUT), 16'h0);
                return;
            end
            @(negedge CLK);
        end
        ack_model(d1, h1, rw, ok);
        if (!ok) begin
            timeout_checks();
            return;
        end
        if (rw) begin
            for (int i = 0; i < 8; i++) begin
                chk("wr_bit", 16'(B_BUS_OUT), 16'((data >> i) & 8'h1));
                chk("wr_rw", 16'(B_RW), 16'h1);
                chk("wr_adsel", 16'(AD_SEL), 16'h0);
                @(negedge CLK);
            end
            ack_model(d2, h2, 1'b1, ok);
            if (!ok) begin
                timeout_checks();
                return;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                B_BUS_IN = 1'((rdat >> i) & 8'h1);
                chk("rd_rw", 16'(B_RW), 16'h0);
                chk("rd_dout_hold", 16'(M_DOUT), 16'(exp_dout));
                @(negedge CLK);
            end
            B_BUS_IN = 1'b0;
            exp_dout = rdat;
        end
        chk("done_pulse", 16'(M_DONE), 16'h1);
        chk("done_err", 16'(M_ERR), 16'h0);
        chk("done_ready", 16'(M_READY), 16'h0);
        chk("done_rw", 16'(B_RW), 16'h0);
        chk("done_dout", 16'(M_DOUT), 16'(exp_dout));
        prev_done = 1'b1;
    endtask

    initial begin
        RSTN = 1'b0; M_EXECUTE = 1'b0; M_RW = 1'b0; M_ADDR = '0; M_DIN = '0;
        B_ACK = 1'b0; B_SBSY = 1'b0; B_BUS_IN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_ready", 16'(M_READY), 16'h1);
        chk("reset_dout", 16'(M_DOUT), 16'h0);
        chk("reset_done", 16'(M_DONE), 16'h0);
        chk("reset_err", 16'(M_ERR), 16'h0);
        chk("reset_adsel", 16'(AD_SEL), 16'h0);
        chk("reset_rw", 16'(B_RW), 16'h0);
        chk("reset_busout", 16'(B_BUS_OUT), 16'h0);
        RSTN = 1'b1;
        @(negedge CLK);

        do_txn(1'b1, 16'h1234, 8'hA5, 8'h00, 2, 1, 2, 1, -1);
        do_txn(1'b0, 16'h0008, 8'h00, 8'h3C, 1, 2, 0, 0, -1);
        do_txn(1'b1, 16'hBEEF, 8'h5A, 8'h00, 99, 0, 0, 0, -1);
        do_txn(1'b0, 16'h4321, 8'h00, 8'hC3, 1, 7, 0, 0, -1);
        do_txn(1'b0, 16'h8001, 8'h00, 8'h96, 0, 7, 0, 0, -1);
        do_txn(1'b1, 16'h0F0F, 8'h77, 8'h00, 0, 1, 3, 5, -1);

        // Busy slave holds off the request until released.
        B_SBSY = 1'b1; M_EXECUTE = 1'b1; M_RW = 1'b1; M_ADDR = 16'h00FF; M_DIN = 8'h81;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("sbsy_adsel", 16'(AD_SEL), 16'h0);
            chk("sbsy_ready", 16'(M_READY), 16'h1);
        end
        B_SBSY = 1'b0;
        do_txn(1'b1, 16'h00FF, 8'h81, 8'h00, 0, 2, 1, 1, -1);

        do_txn(1'b1, 16'hA5A5, 8'h3C, 8'h00, 1, 1, 1, 1, 7);
        @(negedge CLK);
        chk("rst_hold_adsel", 16'(AD_SEL), 16'h0);
        RSTN = 1'b1;
        do_txn(1'b1, 16'h5A5A, 8'hC3, 8'h00, 2, 1, 2, 1, -1);

        M_EXECUTE = 1'b1;
        do_txn(1'b1, 16'h1111, 8'h11, 8'h00, 0, 1, 0, 1, -1);
        do_txn(1'b1, 16'hEEEE, 8'hEE, 8'h00, 0, 1, 0, 1, -1);

        for (int n = 0; n < 12; n++) begin
            int d1, h1, d2, h2;
            d1 = $urandom_range(0, 3); h1 = $urandom_range(1, 4);
            d2 = $urandom_range(0, 3); h2 = $urandom_range(1, 4);
            do_txn(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), d1, h1, d2, h2, -1);
        end
        M_EXECUTE = 1'b0;
        @(negedge CLK);
        chk("final_ready", 16'(M_READY), 16'h1);
        chk("final_dout", 16'(M_DOUT), 16'(exp_dout));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
